pc_seq: RTL and testbench

- Parametrised program-counter sequencer; successor to the single-step edge-triggered counter.
- Adds a selectable increment mode, absolute load, signed relative branch, and a call/return stack of configurable depth.
- Sits between the instruction-fetch controller and program memory.
- Drives the fetch address every cycle.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/pc_stack.sv | 67 ++++++
 rtl/pc_seq.sv | 125 ++++++++++++
 tb/tb_pc_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_pkg                                                     |
// | Purpose : Shared command encoding and address arithmetic for the     |
// |           program-counter sequencer.                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package pc_pkg;

  // Widest PC supported by the shared adder; callers zero-extend into it
  // and keep only their own low SIZE bits, which gives modulo-2^SIZE math.
  localparam int PC_MAX_W = 32;

  // One winning command per cycle, chosen by the priority encoder.
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_STEP   = 3'd1,
    CMD_BRANCH = 3'd2,
    CMD_LOAD   = 3'd3,
    CMD_CALL   = 3'd4,
    CMD_RET    = 3'd5
  } cmd_e;

  // Modular add; two's-complement offsets fall out naturally once the
  // caller truncates the sum to its PC width.
  function automatic logic [PC_MAX_W-1:0] pc_add(input logic [PC_MAX_W-1:0] base,
                                                 input logic [PC_MAX_W-1:0] offset);
    return base + offset;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_stack                                                   |
// | Purpose : Return-address LIFO. Push to full and pop from empty are   |
// |           silently ignored; the parent reports the error.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  import pc_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count_d, count_q;
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Flags come straight from the registered occupancy count.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Select the most recently pushed entry as the visible top.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) top = mem_q[i];
    end
  end

  // Next occupancy and storage; push wins over pop if both ever arrive.
  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q == CW'(i)) mem_d[i] = push_data;
      end
      count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_seq                                                     |
// | Purpose : Program-counter sequencer with step, absolute load,        |
// |           relative branch and call/return stack. Registered outputs. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pc_seq #(
  parameter int SIZE        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int EDGE_MODE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            incr,
  input  logic            load,
  input  logic [SIZE-1:0] load_addr,
  input  logic            branch,
  input  logic [SIZE-1:0] offset,
  input  logic            call,
  input  logic            ret,
  output logic [SIZE-1:0] out,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            err
);
  import pc_pkg::*;

  cmd_e                cmd;
  logic                step_req;
  logic [SIZE-1:0]     out_d, out_q;
  logic                err_d, err_q;
  logic                incr_hist_d, incr_hist_q;
  logic                push, pop;
  logic [SIZE-1:0]     push_data;
  logic [SIZE-1:0]     stk_top;
  logic                stk_full, stk_empty;
  logic [PC_MAX_W-1:0] inc_sum, br_sum;
  logic                unused_sum_hi;

  pc_stack #(
    .WIDTH (SIZE),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Wide sums; only the low SIZE bits matter, which gives the wrap-around.
  always_comb begin
    inc_sum       = pc_add(PC_MAX_W'(out_q), PC_MAX_W'(1));
    br_sum        = pc_add(PC_MAX_W'(out_q), PC_MAX_W'(offset));
    unused_sum_hi = ^{inc_sum, br_sum};
  end

  // Priority encoder: ret > call > load > branch > step.
  always_comb begin
    step_req = incr & ((EDGE_MODE == 0) | ~incr_hist_q);
    cmd      = CMD_NONE;
    if (ret)           cmd = CMD_RET;
    else if (call)     cmd = CMD_CALL;
    else if (load)     cmd = CMD_LOAD;
    else if (branch)   cmd = CMD_BRANCH;
    else if (step_req) cmd = CMD_STEP;
  end

  // Execute the winning command; incr history always tracks incr so a
  // masked edge is consumed rather than deferred.
  always_comb begin
    out_d       = out_q;
    err_d       = err_q;
    incr_hist_d = incr;
    push        = 1'b0;
    pop         = 1'b0;
    push_data   = inc_sum[SIZE-1:0];
    case (cmd)
      CMD_RET: begin
        if (!stk_empty) begin
          out_d = stk_top;
          pop   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_CALL: begin
        if (!stk_full) begin
          push  = 1'b1;
          out_d = load_addr;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_LOAD:   out_d = load_addr;
      CMD_BRANCH: out_d = br_sum[SIZE-1:0];
      CMD_STEP:   out_d = inc_sum[SIZE-1:0];
      default:    ;
    endcase
  end

  // PC, sticky error and incr history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      err_q       <= 1'b0;
      incr_hist_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      err_q       <= err_d;
      incr_hist_q <= incr_hist_d;
    end
  end

  assign out         = out_q;
  assign err         = err_q;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pc_seq                                                  |
// | Purpose : Self-checking bench for pc_seq; edge-mode and level-mode   |
// |           instances share stimulus and a behavioural model.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_pc_seq;

  logic       clk = 1'b0;
  logic       reset, incr, load, branch, call, ret;
  logic [7:0] load_addr, offset;
  logic [7:0] out_e, out_l;
  logic       emp_e, emp_l, ful_e, ful_l, err_e, err_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_seq #(.SIZE(8), .STACK_DEPTH(4), .EDGE_MODE(1)) dut (
    .clk(clk), .reset(reset), .incr(incr), .load(load), .load_addr(load_addr),
    .branch(branch), .offset(offset), .call(call), .ret(ret),
    .out(out_e), .stack_empty(emp_e), .stack_full(ful_e), .err(err_e));

  pc_seq #(.SIZE(8), .STACK_DEPTH(4), .EDGE_MODE(0)) dut_lvl (
    .clk(clk), .reset(reset), .incr(incr), .load(load), .load_addr(load_addr),
    .branch(branch), .offset(offset), .call(call), .ret(ret),
    .out(out_l), .stack_empty(emp_l), .stack_full(ful_l), .err(err_l));

  // Behavioural model; index 1 = edge mode, index 0 = level mode.
  int m_pc [2];
  int m_cnt[2];
  int m_err[2];
  int m_prev[2];
  int m_stk[2][4];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pc[m] = 0; m_cnt[m] = 0; m_err[m] = 0; m_prev[m] = 0;
    end
  endtask

  // Apply one clock of the command rules to the model, from current inputs.
  task automatic model_clock();
    if (reset) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      bit step_ok;
      step_ok = incr && (m == 0 || m_prev[m] == 0);
      if (ret) begin
        if (m_cnt[m] > 0) begin
          m_cnt[m]--;
          m_pc[m] = m_stk[m][m_cnt[m]];
        end else m_err[m] = 1;
      end else if (call) begin
        if (m_cnt[m] < 4) begin
          m_stk[m][m_cnt[m]] = (m_pc[m] + 1) % 256;
          m_cnt[m]++;
          m_pc[m] = int'(load_addr);
        end else m_err[m] = 1;
      end else if (load)   m_pc[m] = int'(load_addr);
      else if (branch)     m_pc[m] = (m_pc[m] + int'(offset)) % 256;
      else if (step_ok)    m_pc[m] = (m_pc[m] + 1) % 256;
      m_prev[m] = incr ? 1 : 0;
    end
  endtask

  task automatic check_model();
    chk8("model_out_edge", out_e, 8'(m_pc[1]));
    chk1("model_empty_edge", emp_e, m_cnt[1] == 0);
    chk1("model_full_edge", ful_e, m_cnt[1] == 4);
    chk1("model_err_edge", err_e, m_err[1] != 0);
    chk8("model_out_lvl", out_l, 8'(m_pc[0]));
    chk1("model_empty_lvl", emp_l, m_cnt[0] == 0);
    chk1("model_full_lvl", ful_l, m_cnt[0] == 4);
    chk1("model_err_lvl", err_l, m_err[0] != 0);
  endtask

  // One clock: model sees the same sampled inputs, outputs checked after edge.
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic clear_inputs();
    incr = 0; load = 0; branch = 0; call = 0; ret = 0;
    load_addr = 8'h00; offset = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  typedef struct {
    logic       incr, load, branch, call, ret;
    logic [7:0] la, off, e_out;
    logic       e_empty, e_full, e_err;
  } vec_t;

  function automatic vec_t mk(logic i, logic ld, logic br, logic ca, logic rt,
                              logic [7:0] la, logic [7:0] off, logic [7:0] eo,
                              logic ee, logic ef, logic er);
    vec_t v;
    v.incr = i; v.load = ld; v.branch = br; v.call = ca; v.ret = rt;
    v.la = la; v.off = off; v.e_out = eo;
    v.e_empty = ee; v.e_full = ef; v.e_err = er;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    // Expected values for the edge-mode instance, applied from reset.
    //           incr ld br ca rt  la     off    out    emp ful err
    tbl[0]  = mk(0, 1, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 8'h00, 8'hF0, 8'h00, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h05, 8'h05, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 8'h40, 8'h00, 8'h40, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 8'h50, 8'h00, 8'h50, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0, 8'h60, 8'h00, 8'h60, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 8'h70, 8'h00, 8'h70, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 8'h80, 8'h00, 8'h70, 0, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h61, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h51, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h41, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 1, 0, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h22, 1, 0, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h22, 1, 0, 1);

    reset = 1;
    clear_inputs();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk8("reset_out", out_e, 8'h00);
    chk1("reset_empty", emp_e, 1'b1);
    chk1("reset_full", ful_e, 1'b0);
    chk1("reset_err", err_e, 1'b0);
    reset = 0;

    // Edge vs level stepping with incr held high for 5 cycles
    incr = 1;
    repeat (5) tick();
    chk8("edge_hold_out", out_e, 8'h01);
    chk8("level_hold_out", out_l, 8'h05);
    incr = 0;
    tick();

    // Table-driven directed sequence
    do_reset();
    for (int i = 0; i < 19; i++) begin
      incr = tbl[i].incr; load = tbl[i].load; branch = tbl[i].branch;
      call = tbl[i].call; ret = tbl[i].ret;
      load_addr = tbl[i].la; offset = tbl[i].off;
      tick();
      chk8("tbl_out", out_e, tbl[i].e_out);
      chk1("tbl_empty", emp_e, tbl[i].e_empty);
      chk1("tbl_full", ful_e, tbl[i].e_full);
      chk1("tbl_err", err_e, tbl[i].e_err);
    end

    // Same-cycle ret + load + rising incr: ret wins, edge is consumed
    do_reset();
    load = 1; load_addr = 8'h32; tick();
    load = 0; call = 1; load_addr = 8'h90; tick();
    call = 0; ret = 1; load = 1; load_addr = 8'h55; incr = 1; tick();
    chk8("prio_ret_out", out_e, 8'h33);
    chk1("prio_ret_err", err_e, 1'b0);
    ret = 0; load = 0; tick();
    chk8("edge_consumed_out", out_e, 8'h33);
    chk8("level_after_ret_out", out_l, 8'h34);
    tick();
    chk8("edge_consumed_out2", out_e, 8'h33);
    incr = 0; tick();

    // Empty-stack ret sets a sticky err
    do_reset();
    ret = 1; tick();
    chk1("ret_empty_err", err_e, 1'b1);
    chk8("ret_empty_out", out_e, 8'h00);
    ret = 0; load = 1; load_addr = 8'h07; tick();
    chk1("err_sticky_load", err_e, 1'b1);
    chk8("err_sticky_out", out_e, 8'h07);
    load = 0; call = 1; load_addr = 8'hA0; tick();
    chk1("err_sticky_call", err_e, 1'b1);

    // Asynchronous reset in the middle of a call sequence
    load_addr = 8'hB0; tick();
    chk1("pre_async_empty", emp_e, 1'b0);
    #2 reset = 1;
    #1;
    chk8("async_out", out_e, 8'h00);
    chk1("async_empty", emp_e, 1'b1);
    chk1("async_err", err_e, 1'b0);
    chk8("async_out_lvl", out_l, 8'h00);
    model_reset();
    clear_inputs();
    tick();
    reset = 0;
    load = 1; load_addr = 8'h44; tick();
    chk8("post_async_load", out_e, 8'h44);
    load = 0;

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) incr = ~incr;
      load      = ($urandom_range(0, 7) == 0);
      branch    = ($urandom_range(0, 7) == 0);
      call      = ($urandom_range(0, 5) == 0);
      ret       = ($urandom_range(0, 4) == 0);
      load_addr = 8'($urandom);
      offset    = 8'($urandom);
      reset     = ($urandom_range(0, 79) == 0);
      tick();
      reset = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
